// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants, types and helpers for the TMDS channel encoder.
//   CNT_W              width of the signed running-disparity counter
//   CTRL_SYM_xx        DVI control symbols for c1c0 = 00/01/10/11
//   GUARD_SYM_*        data-island guard-band symbols (TMDS_TERC4_EN only)
//   TERC4_SYM          16-entry TERC4 symbol table (TMDS_TERC4_EN only)
//   sym_kind_e         stage-2 symbol class selector
//   qm_t               stage-1 register bundle handed to stage 2
//   popcount8()        number of ones in a byte
// Optional feature macro: TMDS_TERC4_EN
package tmds_pkg;

  localparam int unsigned CNT_W = 5;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

`ifdef TMDS_TERC4_EN
  localparam logic [9:0] GUARD_SYM_BR = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_G  = 10'b0100110011;

  localparam logic [9:0] TERC4_SYM [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
`endif

  typedef enum logic [1:0] {
    SYM_CTRL,
    SYM_DATA,
    SYM_GUARD,
    SYM_ISLAND
  } sym_kind_e;

  typedef struct packed {
    logic [8:0] q_m;
    logic       de;
    logic       c0;
    logic       c1;
`ifdef TMDS_TERC4_EN
    logic       island;
    logic       guard;
    logic [3:0] aux;
`endif
  } qm_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    logic [9:0] s;
    unique case ({c1, c0})
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_encoder_qm_stage.sv
// tmds_qm_stage: first pipeline stage of the TMDS encoder. Builds the 9-bit
// transition-minimised word q_m from the pixel byte and registers it together
// with de/c0/c1 (and island/guard/aux when TMDS_TERC4_EN is defined).
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset, clears the whole bundle
//   data_in    pixel byte
//   de_in      data enable
//   c0_in      control bit 0
//   c1_in      control bit 1
//   island_in  data-island period        (TMDS_TERC4_EN only)
//   guard_in   guard-band period         (TMDS_TERC4_EN only)
//   aux_in     TERC4 nibble              (TMDS_TERC4_EN only)
//   qm_out     registered stage-1 bundle
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       de_in,
  input  logic       c0_in,
  input  logic       c1_in,
`ifdef TMDS_TERC4_EN
  input  logic       island_in,
  input  logic       guard_in,
  input  logic [3:0] aux_in,
`endif
  output qm_t        qm_out
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;

  always_comb begin
    n1d      = popcount8(data_in);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_in[0]);
    q_m      = '0;
    q_m[0]   = data_in[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data_in[i]) : (q_m[i-1] ^ data_in[i]);
    end
    q_m[8]   = ~use_xnor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qm_out <= '0;
    end else begin
      qm_out.q_m    <= q_m;
      qm_out.de     <= de_in;
      qm_out.c0     <= c0_in;
      qm_out.c1     <= c1_in;
`ifdef TMDS_TERC4_EN
      qm_out.island <= island_in;
      qm_out.guard  <= guard_in;
      qm_out.aux    <= aux_in;
`endif
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI/HDMI TMDS 8b/10b channel encoder, two-stage pipeline.
// Stage 1 (tmds_qm_stage) does transition minimisation; stage 2 (here) does
// running-disparity DC balancing and control / guard / TERC4 symbol muxing.
// Parameters:
//   CHANNEL    link channel index (0 blue, 1 green, 2 red), picks guard symbol
//   RESET_SYM  symbol driven on tmds_out while in reset
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   data_in    pixel byte, used when de_in=1
//   de_in      data enable
//   c0_in      control bit 0 (hsync on channel 0)
//   c1_in      control bit 1 (vsync on channel 0)
//   island_in  data-island period        (TMDS_TERC4_EN only)
//   guard_in   guard-band period         (TMDS_TERC4_EN only)
//   aux_in     TERC4 nibble              (TMDS_TERC4_EN only)
//   tmds_out   registered 10-bit symbol, bit 0 first on the wire
// Optional feature macro: TMDS_TERC4_EN
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNEL   = 0,
  parameter logic [9:0]  RESET_SYM = 10'b1101010100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       de_in,
  input  logic       c0_in,
  input  logic       c1_in,
`ifdef TMDS_TERC4_EN
  input  logic       island_in,
  input  logic       guard_in,
  input  logic [3:0] aux_in,
`endif
  output logic [9:0] tmds_out
);

  if (CHANNEL > 2) begin : g_channel_check
    $error("tmds_encoder: CHANNEL must be 0, 1 or 2");
  end

  qm_t s1;

  tmds_qm_stage u_qm_stage (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .de_in     (de_in),
    .c0_in     (c0_in),
    .c1_in     (c1_in),
`ifdef TMDS_TERC4_EN
    .island_in (island_in),
    .guard_in  (guard_in),
    .aux_in    (aux_in),
`endif
    .qm_out    (s1)
  );

  sym_kind_e               kind;
  logic [7:0]              q;
  logic                    q8;
  logic [3:0]              n1;
  logic signed [CNT_W-1:0] diff;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic [9:0]              sym_next;

  // Guard beats island beats video data beats plain control.
  always_comb begin
    kind = SYM_CTRL;
`ifdef TMDS_TERC4_EN
    if (s1.guard)       kind = SYM_GUARD;
    else if (s1.island) kind = SYM_ISLAND;
    else
`endif
    if (s1.de)          kind = SYM_DATA;
  end

  always_comb begin
    q        = s1.q_m[7:0];
    q8       = s1.q_m[8];
    n1       = popcount8(q);
    // n1 - n0 = 2*n1 - 8, formed modulo 2^CNT_W so +8 lands correctly.
    diff     = $signed({n1, 1'b0} - 5'd8);
    sym_next = ctrl_sym(s1.c1, s1.c0);
    cnt_next = '0;
    unique case (kind)
      SYM_DATA: begin
        if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
          sym_next = {~q8, q8, (q8 ? q : ~q)};
          cnt_next = cnt + (q8 ? diff : -diff);
        end else if (((cnt > 5'sd0) && (n1 > 4'd4)) ||
                     ((cnt < 5'sd0) && (n1 < 4'd4))) begin
          sym_next = {1'b1, q8, ~q};
          cnt_next = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
        end else begin
          sym_next = {1'b0, q8, q};
          cnt_next = cnt - (q8 ? 5'sd0 : 5'sd2) + diff;
        end
      end
`ifdef TMDS_TERC4_EN
      SYM_GUARD:  sym_next = (CHANNEL == 1) ? GUARD_SYM_G : GUARD_SYM_BR;
      SYM_ISLAND: sym_next = TERC4_SYM[s1.aux];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmds_out <= RESET_SYM;
      cnt      <= '0;
    end else begin
      tmds_out <= sym_next;
      cnt      <= cnt_next;
    end
  end

endmodule
